wp_input_conditioner: RTL and testbench
=======================================

// Module: wp_input_conditioner
// PURPOSE
//   Input-side front end for wiRedPanda-generated circuits. Generated modules drive LEDs from internal state.
//   This block conditions asynchronous board inputs (push-buttons, switches) before they enter a generated module.
//   Per channel it provides a 2-FF synchronizer, a counter-based debouncer and one-cycle rise/fall pulses.
//   The pulses are for circuits that expect clean edges, e.g. the clock of a D flip-flop.
// PARAMETERS
//   WIDTH            4    number of independent input channels (>=1)
//   SYNC_STAGES      2    synchronizer flops per channel (>=2)
//   DEBOUNCE_CYCLES  16   consecutive stable cycles required to accept a new level (>=1)
// PORTS
//   clk         in   1      single system clock; all flops on posedge
//   rst_n       in   1      asynchronous active-low reset
//   raw_in      in   WIDTH  unsynchronized board inputs
//   level_out   out  WIDTH  debounced level
//   rise_pulse  out  WIDTH  1-cycle pulse when level_out goes 0->1
//   fall_pulse  out  WIDTH  1-cycle pulse when level_out goes 1->0
//   any_busy    out  1      OR over channels of "debounce counter nonzero"
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync chains, counters, level_out, rise_pulse, fall_pulse and any_busy all clear to 0.
//     Reset has immediate effect and may occur mid-count; the count in progress is discarded with no pulse.
//   - Synchronizer: s = last stage of a SYNC_STAGES shift register clocked from raw_in[i].
//   - Debounce per channel, with cnt of width clog2(DEBOUNCE_CYCLES)+1:
//       s == level: cnt <= 0.
//       s != level and cnt <  DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//       s != level and cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0, and the matching pulse fires.
//   - Any cycle where s returns to level clears cnt. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches level_out.
//   - Latency: a clean step on raw_in changes level_out exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges later.
//     The pulse rises on the same edge as level_out changes.
//   - rise_pulse/fall_pulse are registered. Each is high for exactly one cycle per accepted transition.
//     rise and fall of the same channel are never high together.
//   - With DEBOUNCE_CYCLES=1, a level change is accepted on the first cycle s differs (pure synchronizer + edge detect).
//   - Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
//   - No combinational path from any input to any output.
// CONFIGURATION
//   WP_INPUT_TOGGLE_EN defined:
//     - Adds output port toggle_out [WIDTH], reset 0.
//     - toggle_out[i] inverts on the edge where rise_pulse[i] asserts (push-button acts as a toggle switch).
//     - The new value is visible in the cycle after that edge.
//   WP_INPUT_TOGGLE_EN undefined: no toggle_out port and no toggle flops; all other behaviour is identical.
// STRUCTURE
//   - Package wp_input_pkg:
//       wp_clog2 function;
//       typedef enum {WP_EDGE_NONE, WP_EDGE_RISE, WP_EDGE_FALL} wp_edge_t;
//       default localparams for the SYNC_STAGES and DEBOUNCE_CYCLES defaults.
//   - Sub-module wp_debounce_ch: one channel (sync chain, counter, level, edge pulses, optional toggle).
//     Instantiated WIDTH times in a generate loop.
//   - Top level: replication plus any_busy reduction only.
// TESTING (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   1. Clean step: raw_in 0000->0001 held.
//      -> level_out[0]=1 exactly 6 edges later; rise_pulse=0001 for 1 cycle; others stay 0.
//   2. Glitch: raw_in[1]=1 for 3 cycles then 0.
//      -> level_out, rise_pulse and fall_pulse stay 0000; any_busy high during the glitch then 0.
//   3. Bounce: raw_in[2] pattern 1,0,1,1,0,1 then held 1.
//      -> exactly one rise_pulse[2], 6 edges after the final 0->1.
//   4. Simultaneous: raw_in 0000->1111, then 1111->0000 after 10 cycles.
//      -> rise_pulse=1111 on one cycle; later fall_pulse=1111 on one cycle.
//   5. Reset mid-count: raw_in[3]=1, rst_n low after 2 debounce cycles, release, raw_in[3] held 1.
//      -> during reset all outputs 0; after release level_out[3]=1 6 edges later, single pulse.
//   6. WP_INPUT_TOGGLE_EN: two clean presses on channel 0 -> toggle_out[0] 0->1->0; undefined build compiles without the port.

Source files
------------

// File: rtl/wp_input_pkg.sv
// Shared types, defaults and helpers for the wiRedPanda input conditioner.
// Latency: n/a (declarations only). Backpressure: none.
package wp_input_pkg;

    localparam int WP_DEF_SYNC_STAGES     = 2;
    localparam int WP_DEF_DEBOUNCE_CYCLES = 16;

    typedef enum logic [1:0] {
        WP_EDGE_NONE = 2'd0,
        WP_EDGE_RISE = 2'd1,
        WP_EDGE_FALL = 2'd2
    } wp_edge_t;

    function automatic int wp_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wp_debounce_ch.sv
// One input channel: sync chain, debounce counter, level and edge pulses (toggle when WP_INPUT_TOGGLE_EN).
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from raw step to level/pulse. Backpressure: none.
module wp_debounce_ch
    import wp_input_pkg::*;
#(
    parameter int SYNC_STAGES     = WP_DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = WP_DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
`ifdef WP_INPUT_TOGGLE_EN
    ,
    output logic toggle_out
`endif
);

    localparam int                CNT_W    = wp_clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, fall_q;
    wp_edge_t               edge_kind_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Any cycle the synchronized input agrees with the accepted level restarts the count.
    always_comb begin
        cnt_d       = cnt_q;
        level_d     = level_q;
        edge_kind_d = WP_EDGE_NONE;
        if (sync_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            level_d     = sync_s;
            edge_kind_d = sync_s ? WP_EDGE_RISE : WP_EDGE_FALL;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_in};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= (edge_kind_d == WP_EDGE_RISE);
            fall_q  <= (edge_kind_d == WP_EDGE_FALL);
        end
    end

`ifdef WP_INPUT_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else if (edge_kind_d == WP_EDGE_RISE) begin
            toggle_q <= ~toggle_q;
        end
    end

    assign toggle_out = toggle_q;
`endif

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = |cnt_q;

endmodule

// File: rtl/wp_input_conditioner.sv
// Conditions WIDTH async board inputs into debounced levels and edge pulses; toggle_out with WP_INPUT_TOGGLE_EN.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges per accepted step. Backpressure: none.
module wp_input_conditioner
    import wp_input_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = WP_DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = WP_DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_busy
`ifdef WP_INPUT_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] toggle_out
`endif
);

    logic [WIDTH-1:0] busy_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        wp_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw_in    (raw_in[i]),
            .level_out (level_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i]),
            .busy      (busy_vec[i])
`ifdef WP_INPUT_TOGGLE_EN
            ,
            .toggle_out(toggle_out[i])
`endif
        );
    end

    // Busy is driven straight from counter flops, so it carries no input-to-output path.
    assign any_busy = |busy_vec;

endmodule

// File: tb/tb_wp_input_conditioner.sv
// Bench for wp_input_conditioner (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4): pulse scoreboard plus inline checks.
module tb_wp_input_conditioner;

    localparam int W   = 4;
    localparam int LAT = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] level_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         any_busy;
`ifdef WP_INPUT_TOGGLE_EN
    logic [W-1:0] toggle_out;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int           cyc;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_e;

    wp_input_conditioner #(
        .WIDTH          (W),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (raw_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_busy  (any_busy)
`ifdef WP_INPUT_TOGGLE_EN
        ,
        .toggle_out(toggle_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every nonzero pulse cycle must match the oldest pending expectation.
    always @(negedge clk) begin
        if ((rise_pulse | fall_pulse) !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected cyc=%0d rise=%b fall=%b want no pulse", cyc, rise_pulse, fall_pulse);
            end else begin
                got_e = exp_q.pop_front();
                if (got_e.cyc !== cyc || got_e.rise !== rise_pulse || got_e.fall !== fall_pulse) begin
                    bad++;
                    $display("FAIL pulse_event got cyc=%0d rise=%b fall=%b want cyc=%0d rise=%b fall=%b",
                             cyc, rise_pulse, fall_pulse, got_e.cyc, got_e.rise, got_e.fall);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int at, input logic [W-1:0] r, input logic [W-1:0] f);
        ev_t e;
        e.cyc  = at;
        e.rise = r;
        e.fall = f;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        raw_in = '0;
        tick(2);
        total++;
        if ({level_out, rise_pulse, fall_pulse, any_busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got lvl=%b r=%b f=%b busy=%b want all 0", level_out, rise_pulse, fall_pulse, any_busy);
        end
        rst_n = 1'b1;
        tick(3);
        total++;
        if (level_out !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release_level got=%b want=0000", level_out);
        end
    endtask

    task automatic test_clean_step();
        int k;
        k = cyc;
        raw_in = 4'b0001;
        push_ev(k + LAT, 4'b0001, 4'b0000);
        tick(LAT - 1);
        total++;
        if (level_out !== 4'b0000) begin
            bad++;
            $display("FAIL clean_early_level got=%b want=0000", level_out);
        end
        tick(1);
        total++;
        if (level_out !== 4'b0001 || rise_pulse !== 4'b0001) begin
            bad++;
            $display("FAIL clean_accept got lvl=%b rise=%b want lvl=0001 rise=0001", level_out, rise_pulse);
        end
        tick(1);
        total++;
        if (rise_pulse !== 4'b0000 || level_out !== 4'b0001) begin
            bad++;
            $display("FAIL clean_one_cycle got lvl=%b rise=%b want lvl=0001 rise=0000", level_out, rise_pulse);
        end
        k = cyc;
        raw_in = 4'b0000;
        push_ev(k + LAT, 4'b0000, 4'b0001);
        tick(LAT + 2);
        total++;
        if (level_out !== 4'b0000 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL clean_release got lvl=%b pending=%0d want lvl=0000 pending=0", level_out, exp_q.size());
        end
    endtask

    task automatic test_glitch();
        raw_in = 4'b0010;
        tick(3);
        raw_in = 4'b0000;
        total++;
        if (any_busy !== 1'b1) begin
            bad++;
            $display("FAIL glitch_busy got=%b want=1", any_busy);
        end
        tick(LAT + 2);
        total++;
        if (level_out !== 4'b0000 || any_busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch_after got lvl=%b busy=%b want lvl=0000 busy=0", level_out, any_busy);
        end
    endtask

    task automatic test_boundary();
        int k;
        k = cyc;
        raw_in = 4'b0010;
        push_ev(k + LAT, 4'b0010, 4'b0000);
        tick(4);
        raw_in = 4'b0000;
        push_ev(k + 4 + LAT, 4'b0000, 4'b0010);
        tick(LAT + 4);
        total++;
        if (level_out !== 4'b0000 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL boundary_pulse got lvl=%b pending=%0d want lvl=0000 pending=0", level_out, exp_q.size());
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int         k;
        pat = 6'b101101;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            raw_in = {1'b0, pat[5 - i], 2'b00};
            k = cyc;
            if (i < 5) tick(1);
        end
        push_ev(k + LAT, 4'b0100, 4'b0000);
        tick(LAT + 2);
        total++;
        if (level_out !== 4'b0100 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bounce_accept got lvl=%b pending=%0d want lvl=0100 pending=0", level_out, exp_q.size());
        end
        k = cyc;
        raw_in = 4'b0000;
        push_ev(k + LAT, 4'b0000, 4'b0100);
        tick(LAT + 2);
    endtask

    task automatic test_simultaneous();
        int k;
        k = cyc;
        raw_in = 4'b1111;
        push_ev(k + LAT, 4'b1111, 4'b0000);
        tick(10);
        total++;
        if (level_out !== 4'b1111) begin
            bad++;
            $display("FAIL simul_rise_level got=%b want=1111", level_out);
        end
        k = cyc;
        raw_in = 4'b0000;
        push_ev(k + LAT, 4'b0000, 4'b1111);
        tick(LAT + 2);
        total++;
        if (level_out !== 4'b0000 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL simul_fall got lvl=%b pending=%0d want lvl=0000 pending=0", level_out, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_count();
        int k;
        raw_in = 4'b1000;
        tick(4);
        total++;
        if (any_busy !== 1'b1 || level_out !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_counting got busy=%b lvl=%b want busy=1 lvl=0000", any_busy, level_out);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({level_out, rise_pulse, fall_pulse, any_busy} !== '0) begin
            bad++;
            $display("FAIL midreset_async got lvl=%b r=%b f=%b busy=%b want all 0", level_out, rise_pulse, fall_pulse, any_busy);
        end
        tick(2);
        total++;
        if ({level_out, rise_pulse, fall_pulse, any_busy} !== '0) begin
            bad++;
            $display("FAIL midreset_held got lvl=%b r=%b f=%b busy=%b want all 0", level_out, rise_pulse, fall_pulse, any_busy);
        end
        rst_n = 1'b1;
        k = cyc;
        push_ev(k + LAT, 4'b1000, 4'b0000);
        tick(LAT + 2);
        total++;
        if (level_out !== 4'b1000 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_after got lvl=%b pending=%0d want lvl=1000 pending=0", level_out, exp_q.size());
        end
        k = cyc;
        raw_in = 4'b0000;
        push_ev(k + LAT, 4'b0000, 4'b1000);
        tick(LAT + 2);
    endtask

`ifdef WP_INPUT_TOGGLE_EN
    task automatic test_toggle();
        int k;
        total++;
        if (toggle_out !== 4'b0000) begin
            bad++;
            $display("FAIL toggle_init got=%b want=0000", toggle_out);
        end
        for (int p = 0; p < 2; p++) begin
            k = cyc;
            raw_in = 4'b0001;
            push_ev(k + LAT, 4'b0001, 4'b0000);
            tick(LAT);
            total++;
            if (toggle_out !== ((p == 0) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL toggle_press%0d got=%b want=%b", p, toggle_out, (p == 0) ? 4'b0001 : 4'b0000);
            end
            k = cyc;
            raw_in = 4'b0000;
            push_ev(k + LAT, 4'b0000, 4'b0001);
            tick(LAT + 2);
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        raw_in = '0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_boundary();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
`ifdef WP_INPUT_TOGGLE_EN
        test_toggle();
`endif
        tick(4);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
